serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor computing d = a - b - bin, LSB first, one bit per clock.
- Each bit slice is a full-subtract cell: two cascaded half-subtract stages with OR-ed borrows, plus a borrow flip-flop carried between bits.
- Sits downstream of operand sources and upstream of any consumer of the difference.
- Uses a valid/ready handshake on both input and output, so operands and results can be buffered and back-pressured.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range is 1 or greater.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands a, b, bin are valid.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in.
- out_valid  output  1  d and bo hold a completed result.
- out_ready  input  1  consumer accepts the result.
- d  output  WIDTH  difference.
- bo  output  1  final borrow-out; 1 when a < b + bin (unsigned).

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; operand shift registers, d, bo, borrow flop and bit counter all cleared to 0.
  - out_valid=0.
  - in_ready=1, because it is decoded from IDLE; handshakes are ignored while rst_n is low.
- States: IDLE, RUN, DONE.
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE).
- IDLE:
  - On a rising edge with in_valid && in_ready: capture a and b into shift registers and bin into the borrow flop; clear the bit counter; go to RUN.
  - Otherwise hold.
- RUN, each edge (bit i = counter value):
  - ai = LSB of the a shift register; bi = LSB of the b shift register; br = borrow flop.
  - di = ai ^ bi ^ br.
  - brnext = (~ai & bi) | (~(ai ^ bi) & br).
  - Shift the a and b registers right by 1.
  - Shift di into the MSB of the d register, which shifts right.
  - Borrow flop <= brnext; counter increments.
  - On the edge processing bit WIDTH-1: state <= DONE and bo <= brnext.
  - After that edge the d register holds the full difference, with bit 0 in d[0].
- Latency: out_valid rises exactly WIDTH clock edges after the acceptance edge.
  - Minimum throughput is one operation per WIDTH+2 cycles (accept, WIDTH RUN edges, one DONE cycle).
- DONE:
  - d and bo are stable.
  - in_valid is ignored (in_ready=0).
  - On an edge with out_ready=1: go to IDLE, so in_ready=1 on the next cycle.
  - No same-cycle accept-and-deliver.
  - out_ready held low: remain in DONE indefinitely with outputs stable.
- d and bo retain the last result in IDLE. They are only meaningful when out_valid=1.
  - In RUN, d shows partial shift contents and must not be used.
- out_ready has no effect outside DONE. in_valid has no effect outside IDLE.
- Changing a, b or bin after acceptance has no effect on the operation in flight.
- Reset asserted mid-RUN or in DONE:
  - Aborts immediately and discards the result.
  - out_valid goes 0 asynchronously.
  - After release the block is in IDLE with all registers zero.
- Wrap-around: the result is the modulo 2^WIDTH difference. bo flags an unsigned underflow.
- Counter width is clog2(WIDTH+1).
- WIDTH=1 must work: RUN lasts one edge.

Test Plan:
- WIDTH=8, a=0x05, b=0x03, bin=0, out_ready=1 -> out_valid high 8 edges after accept; d=0x02, bo=0; in_ready high again the cycle after DONE.
- WIDTH=8, a=0x03, b=0x05, bin=0 -> d=0xFE, bo=1. Then a=0x00, b=0x00, bin=1 -> d=0xFF, bo=1. Then a=0xFF, b=0xFF, bin=0 -> d=0x00, bo=0.
- Backpressure: WIDTH=8, a=0xA0, b=0x0A, bin=0, out_ready held 0 for 5 cycles after out_valid:
  - d=0x96, bo=0 stable throughout; in_ready=0.
  - A new in_valid pulse during this time is ignored.
  - After out_ready=1 for one edge: out_valid=0, in_ready=1.
- Reset mid-operation: accept a=0x80, b=0x01, then drop rst_n low after 3 RUN edges:
  - out_valid=0 and in_ready=1 immediately; d=0, bo=0.
  - A following operation a=0x10, b=0x01 -> d=0x0F, bo=0.
- WIDTH=1 exhaustive over all 8 combinations of a, b, bin:
  - (0,0,0)->d0 b0; (0,1,0)->d1 b1; (1,0,0)->d1 b0; (1,1,0)->d0 b0.
  - (0,0,1)->d1 b1; (0,1,1)->d0 b1; (1,0,1)->d0 b0; (1,1,1)->d1 b1.
  - Each result is valid 1 edge after accept.
- Back-to-back: in_valid held high with random operands and out_ready=1 for 50 operations, WIDTH=8:
  - Every result matches (a - b - bin) mod 256, and bo matches the reference underflow.
  - Consecutive accepts are spaced exactly WIDTH+2 cycles apart.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d;
  logic             bo;

  // Operand source / result consumer side.
  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, d, bo
  );

  // Subtractor side.
  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, d, bo
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: d = a - b - bin, LSB first, one bit per clock.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_subtractor_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] d_q;
  logic [CNT_W-1:0] cnt_q;
  logic             br_q;
  logic             bo_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic ai;
  logic bi;
  logic di;
  logic br_next;

  // Full-subtract cell: two half-subtract stages with OR-ed borrows.
  always_comb begin
    ai      = a_q[0];
    bi      = b_q[0];
    di      = ai ^ bi ^ br_q;
    br_next = (~ai & bi) | (~(ai ^ bi) & br_q);
  end

  // Control FSM and serial datapath; handshake outputs registered with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      br_q        <= 1'b0;
      bo_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            a_q        <= bus.a;
            b_q        <= bus.b;
            br_q       <= bus.bin;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state      <= RUN;
          end
        end
        RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          d_q   <= (d_q >> 1) | (WIDTH'(di) << (WIDTH - 1));
          br_q  <= br_next;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            bo_q        <= br_next;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.d         = d_q;
  assign bus.bo        = bo_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8 and WIDTH=1).
module tb_serial_subtractor;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_fail;

  serial_subtractor_if #(.WIDTH(8)) b8 ();
  serial_subtractor_if #(.WIDTH(1)) b1 ();

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b8.slave)
  );

  serial_subtractor #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation from IDLE (called at posedge+1); returns when out_valid is seen or bound expires.
  task automatic run_op(input bit w1, input logic [7:0] av, input logic [7:0] bv, input logic binv,
                        output logic [7:0] dv, output logic bov, output int lat);
    if (w1) begin
      b1.a = av[0]; b1.b = bv[0]; b1.bin = binv; b1.in_valid = 1'b1;
    end else begin
      b8.a = av; b8.b = bv; b8.bin = binv; b8.in_valid = 1'b1;
    end
    @(posedge clk); #1;
    b1.in_valid = 1'b0; b8.in_valid = 1'b0;
    b1.a = ~av[0]; b1.b = ~bv[0]; b1.bin = ~binv;
    b8.a = ~av; b8.b = ~bv; b8.bin = ~binv;
    lat = 0;
    while (!(w1 ? b1.out_valid : b8.out_valid) && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    dv  = w1 ? {7'b0, b1.d} : b8.d;
    bov = w1 ? b1.bo : b8.bo;
  endtask

  logic [7:0] dv;
  logic       bov;
  int         lat;
  logic [7:0] va [4] = '{8'h03, 8'h00, 8'hFF, 8'h7F};
  logic [7:0] vb [4] = '{8'h05, 8'h00, 8'hFF, 8'h80};
  logic       vc [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [7:0] vd [4] = '{8'hFE, 8'hFF, 8'h00, 8'hFE};
  logic       vo [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
  logic       wa [8] = '{0, 0, 1, 1, 0, 0, 1, 1};
  logic       wb [8] = '{0, 1, 0, 1, 0, 1, 0, 1};
  logic       wc [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
  logic       wd [8] = '{0, 1, 1, 0, 1, 0, 0, 1};
  logic       wo [8] = '{0, 1, 0, 0, 1, 1, 0, 1};

  initial begin
    logic [7:0] ra, rb;
    logic       rc;
    logic [8:0] ref_v;
    int         acc, prev, n;

    n_checks = 0; n_fail = 0; cyc = 0;
    rst_n = 1'b0;
    b8.in_valid = 0; b8.a = '0; b8.b = '0; b8.bin = 0; b8.out_ready = 1;
    b1.in_valid = 0; b1.a = '0; b1.b = '0; b1.bin = 0; b1.out_ready = 1;
    #12;
    check("rst_in_ready", b8.in_ready, 1);
    check("rst_out_valid", b8.out_valid, 0);
    check("rst_d", b8.d, 0);
    check("rst_bo", b8.bo, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic operation and latency
    run_op(0, 8'h05, 8'h03, 0, dv, bov, lat);
    check("basic_lat", lat, 8);
    check("basic_d", dv, 8'h02);
    check("basic_bo", bov, 0);
    check("basic_in_ready_done", b8.in_ready, 0);
    @(posedge clk); #1;
    check("basic_in_ready_after", b8.in_ready, 1);
    check("basic_out_valid_after", b8.out_valid, 0);

    // Underflow / borrow-in / wrap vectors
    for (int i = 0; i < 4; i++) begin
      run_op(0, va[i], vb[i], vc[i], dv, bov, lat);
      check($sformatf("vec%0d_lat", i), lat, 8);
      check($sformatf("vec%0d_d", i), dv, vd[i]);
      check($sformatf("vec%0d_bo", i), bov, vo[i]);
      @(posedge clk); #1;
    end

    // Backpressure
    b8.out_ready = 0;
    run_op(0, 8'hA0, 8'h0A, 0, dv, bov, lat);
    check("bp_d", dv, 8'h96);
    check("bp_bo", bov, 0);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        b8.a = 8'h11; b8.b = 8'h22; b8.bin = 1; b8.in_valid = 1;
      end
      @(posedge clk); #1;
      b8.in_valid = 0;
      check($sformatf("bp%0d_out_valid", k), b8.out_valid, 1);
      check($sformatf("bp%0d_d", k), b8.d, 8'h96);
      check($sformatf("bp%0d_bo", k), b8.bo, 0);
      check($sformatf("bp%0d_in_ready", k), b8.in_ready, 0);
    end
    b8.out_ready = 1;
    @(posedge clk); #1;
    check("bp_rel_out_valid", b8.out_valid, 0);
    check("bp_rel_in_ready", b8.in_ready, 1);
    @(posedge clk); #1;
    check("bp_idle_in_ready", b8.in_ready, 1);
    check("bp_idle_out_valid", b8.out_valid, 0);

    // Reset in the middle of RUN
    b8.a = 8'h80; b8.b = 8'h01; b8.bin = 0; b8.in_valid = 1;
    @(posedge clk); #1;
    b8.in_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mrst_out_valid", b8.out_valid, 0);
    check("mrst_in_ready", b8.in_ready, 1);
    check("mrst_d", b8.d, 0);
    check("mrst_bo", b8.bo, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(0, 8'h10, 8'h01, 0, dv, bov, lat);
    check("mrst_next_lat", lat, 8);
    check("mrst_next_d", dv, 8'h0F);
    check("mrst_next_bo", bov, 0);
    @(posedge clk); #1;

    // WIDTH=1 exhaustive
    for (int i = 0; i < 8; i++) begin
      run_op(1, {7'b0, wa[i]}, {7'b0, wb[i]}, wc[i], dv, bov, lat);
      check($sformatf("w1_%0d_lat", i), lat, 1);
      check($sformatf("w1_%0d_d", i), dv, {7'b0, wd[i]});
      check($sformatf("w1_%0d_bo", i), bov, wo[i]);
      @(posedge clk); #1;
    end

    // Back-to-back with in_valid held high
    prev = 0;
    for (int i = 0; i < 50; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      b8.a = ra; b8.b = rb; b8.bin = rc; b8.in_valid = 1;
      @(posedge clk); #1;
      acc = cyc;
      if (i > 0) check($sformatf("b2b%0d_spacing", i), acc - prev, 10);
      prev = acc;
      b8.a = 8'($urandom); b8.b = 8'($urandom); b8.bin = 1'($urandom);
      n = 0;
      while (!b8.out_valid && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      ref_v = {1'b0, ra} - {1'b0, rb} - 9'(rc);
      check($sformatf("b2b%0d_d", i), b8.d, ref_v[7:0]);
      check($sformatf("b2b%0d_bo", i), b8.bo, ref_v[8]);
      @(posedge clk); #1;
    end
    b8.in_valid = 0;
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
